// File: rtl/arbitro_juego_if.sv
// -----------------------------------------------------------------------------
// arbitro_juego_if
// Player and display bundle of the LED game referee.
//   resetContador : synchronous match clear (toward the referee)
//   botonA/botonB : conditioned player buttons, level (toward the referee)
//   Leds          : LED bar drive, N_LEDS bits (from the referee)
//   PuntosA/B     : 4-bit scores (from the referee)
//   GanadorA/B    : winner flags (from the referee)
//   Apagar        : match over, display off (from the referee)
// Modports: master = the side that drives buttons/clear, slave = the referee.
// -----------------------------------------------------------------------------
interface arbitro_juego_if #(
  parameter int N_LEDS = 8
);
  logic              resetContador;
  logic              botonA;
  logic              botonB;
  logic [N_LEDS-1:0] Leds;
  logic [3:0]        PuntosA;
  logic [3:0]        PuntosB;
  logic              GanadorA;
  logic              GanadorB;
  logic              Apagar;

  modport master (
    output resetContador, botonA, botonB,
    input  Leds, PuntosA, PuntosB, GanadorA, GanadorB, Apagar
  );

  modport slave (
    input  resetContador, botonA, botonB,
    output Leds, PuntosA, PuntosB, GanadorA, GanadorB, Apagar
  );
endinterface

// File: rtl/arbitro_juego.sv
// -----------------------------------------------------------------------------
// arbitro_juego
// Referee and scoring engine for the two-player LED game. A lit LED travels
// along the bar; each player returns it with a button press when it sits on
// their end cell. Misses and early presses give the point to the opponent.
// The first player reaching PUNTOS wins; after TIEMPO_APAGAR ball steps of
// showing the winner's half, Apagar asserts until the match is cleared.
// Ports:
//   clk        : system clock
//   resetTotal : asynchronous active-high reset
//   bus        : arbitro_juego_if.slave (resetContador, buttons, Leds,
//                scores, winner flags, Apagar)
// -----------------------------------------------------------------------------
module arbitro_juego #(
  parameter int N_LEDS        = 8,
  parameter int DIV_TICK      = 25000000,
  parameter int PUNTOS        = 3,
  parameter int TIEMPO_APAGAR = 4
) (
  input  logic            clk,
  input  logic            resetTotal,
  arbitro_juego_if.slave  bus
);

  localparam int POS_W   = $clog2(N_LEDS);
  localparam int PRE_W   = $clog2(DIV_TICK);
  localparam int PASOS_W = (TIEMPO_APAGAR > 1) ? $clog2(TIEMPO_APAGAR) : 1;

  localparam logic [POS_W-1:0]   ULTIMO    = POS_W'(N_LEDS - 1);
  localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(DIV_TICK - 1);
  localparam logic [PASOS_W-1:0] PASOS_MAX = PASOS_W'(TIEMPO_APAGAR - 1);
  localparam logic [3:0]         META      = 4'(PUNTOS);

  localparam logic [N_LEDS-1:0] LED_A   = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] LED_B   = LED_A << (N_LEDS - 1);
  // Lower half belongs to A; with an odd bar the centre LED falls in B's half.
  localparam logic [N_LEDS-1:0] MITAD_A = {N_LEDS{1'b1}} >> (N_LEDS - N_LEDS / 2);

  typedef enum logic [2:0] {
    IDLE,
    MOV_AB,
    MOV_BA,
    PUNTO,
    FIN,
    APAGADO
  } estadoT;

  estadoT             estadoReg, estadoNext;
  logic [POS_W-1:0]   posReg, posNext;
  logic               saqueBReg, saqueBNext;   // 0: A serves, 1: B serves
  logic [PRE_W-1:0]   preReg, preNext;
  logic [PASOS_W-1:0] pasosReg, pasosNext;
  logic [3:0]         puntosAReg, puntosANext;
  logic [3:0]         puntosBReg, puntosBNext;
  logic               ganadorAReg, ganadorANext;
  logic               ganadorBReg, ganadorBNext;
  logic               apagarReg, apagarNext;
  logic [N_LEDS-1:0]  ledsReg, ledsNext;
  logic               botonAPrevReg, botonBPrevReg;

  logic flancoA, flancoB, tick;
  logic puntoParaA, puntoParaB;

  assign flancoA = bus.botonA & ~botonAPrevReg;
  assign flancoB = bus.botonB & ~botonBPrevReg;
  assign tick    = (preReg == PRE_MAX);

  // Edge-detect copies keep tracking the buttons through a match clear so a
  // button still held across the clear cannot fire a phantom serve.
  always_ff @(posedge clk or posedge resetTotal) begin
    if (resetTotal) begin
      botonAPrevReg <= 1'b0;
      botonBPrevReg <= 1'b0;
    end else begin
      botonAPrevReg <= bus.botonA;
      botonBPrevReg <= bus.botonB;
    end
  end

  always_ff @(posedge clk or posedge resetTotal) begin
    if (resetTotal) begin
      estadoReg   <= IDLE;
      posReg      <= '0;
      saqueBReg   <= 1'b0;
      preReg      <= '0;
      pasosReg    <= '0;
      puntosAReg  <= '0;
      puntosBReg  <= '0;
      ganadorAReg <= 1'b0;
      ganadorBReg <= 1'b0;
      apagarReg   <= 1'b0;
      ledsReg     <= '0;
    end else begin
      estadoReg   <= estadoNext;
      posReg      <= posNext;
      saqueBReg   <= saqueBNext;
      preReg      <= preNext;
      pasosReg    <= pasosNext;
      puntosAReg  <= puntosANext;
      puntosBReg  <= puntosBNext;
      ganadorAReg <= ganadorANext;
      ganadorBReg <= ganadorBNext;
      apagarReg   <= apagarNext;
      ledsReg     <= ledsNext;
    end
  end

  always_comb begin
    estadoNext   = estadoReg;
    posNext      = posReg;
    saqueBNext   = saqueBReg;
    preNext      = tick ? '0 : preReg + 1'b1;
    pasosNext    = pasosReg;
    puntosANext  = puntosAReg;
    puntosBNext  = puntosBReg;
    ganadorANext = ganadorAReg;
    ganadorBNext = ganadorBReg;
    apagarNext   = apagarReg;
    ledsNext     = '0;
    puntoParaA   = 1'b0;
    puntoParaB   = 1'b0;

    case (estadoReg)
      IDLE: begin
        // Only the server's edge counts, so a simultaneous edge from the
        // other player is simply dropped.
        if (!saqueBReg && flancoA) begin
          posNext    = '0;
          estadoNext = MOV_AB;
        end else if (saqueBReg && flancoB) begin
          posNext    = ULTIMO;
          estadoNext = MOV_BA;
        end
      end
      MOV_AB: begin
        // The button is checked before the tick so a hit on the last step
        // beats the miss that the same tick would otherwise produce.
        if (flancoB && posReg == ULTIMO) begin
          estadoNext = MOV_BA;
        end else if (flancoB) begin
          puntoParaA = 1'b1;
        end else if (tick) begin
          if (posReg == ULTIMO) puntoParaA = 1'b1;
          else                  posNext = posReg + 1'b1;
        end
      end
      MOV_BA: begin
        if (flancoA && posReg == '0) begin
          estadoNext = MOV_AB;
        end else if (flancoA) begin
          puntoParaB = 1'b1;
        end else if (tick) begin
          if (posReg == '0) puntoParaB = 1'b1;
          else              posNext = posReg - 1'b1;
        end
      end
      PUNTO: begin
        if (tick) begin
          if (puntosAReg == META || puntosBReg == META) begin
            estadoNext   = FIN;
            pasosNext    = '0;
            ganadorANext = (puntosAReg == META);
            ganadorBNext = (puntosAReg != META);
          end else begin
            estadoNext = IDLE;
          end
        end
      end
      FIN: begin
        if (tick) begin
          if (pasosReg == PASOS_MAX) begin
            estadoNext = APAGADO;
            apagarNext = 1'b1;
          end else begin
            pasosNext = pasosReg + 1'b1;
          end
        end
      end
      APAGADO: begin
      end
      default: estadoNext = IDLE;
    endcase

    // The loser of the point serves next.
    if (puntoParaA) begin
      puntosANext = (puntosAReg >= META) ? META : puntosAReg + 4'd1;
      saqueBNext  = 1'b1;
      estadoNext  = PUNTO;
    end
    if (puntoParaB) begin
      puntosBNext = (puntosBReg >= META) ? META : puntosBReg + 4'd1;
      saqueBNext  = 1'b0;
      estadoNext  = PUNTO;
    end

    // Every state entry restarts the step timer, including a return that
    // flips MOV_AB <-> MOV_BA.
    if (estadoNext != estadoReg) preNext = '0;

    // Leds are registered from the next-state values so they change on the
    // same edge as the state they describe.
    case (estadoNext)
      IDLE:           ledsNext = saqueBNext ? LED_B : LED_A;
      MOV_AB, MOV_BA: ledsNext = LED_A << posNext;
      PUNTO:          ledsNext = '1;
      FIN:            ledsNext = ganadorANext ? MITAD_A : ~MITAD_A;
      default:        ledsNext = '0;
    endcase

    if (bus.resetContador) begin
      estadoNext   = IDLE;
      posNext      = '0;
      saqueBNext   = 1'b0;
      preNext      = '0;
      pasosNext    = '0;
      puntosANext  = '0;
      puntosBNext  = '0;
      ganadorANext = 1'b0;
      ganadorBNext = 1'b0;
      apagarNext   = 1'b0;
      ledsNext     = '0;
    end
  end

  assign bus.Leds     = ledsReg;
  assign bus.PuntosA  = puntosAReg;
  assign bus.PuntosB  = puntosBReg;
  assign bus.GanadorA = ganadorAReg;
  assign bus.GanadorB = ganadorBReg;
  assign bus.Apagar   = apagarReg;

endmodule
